// File: rtl/exec_unit_param.sv
// Parametrised execution unit: register file, 16-op ALU, registered flags, PC/IR,
// and a req/rdy memory-read FSM that loads IR or a register from DS.
module exec_unit_param #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int OFS_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          W_en,
    input  logic [AW-1:0] W_Adr,
    input  logic [AW-1:0] R_Adr,
    input  logic [AW-1:0] S_Adr,
    input  logic          s_sel,
    input  logic [3:0]    ALU_OP,
    input  logic          flag_ld,
    input  logic          pc_ld,
    input  logic          pc_sel,
    input  logic          pc_inc,
    input  logic          adr_sel,
    input  logic          mem_start,
    input  logic          mem_dst,
    input  logic          mem_rdy,
    input  logic [DW-1:0] DS,
    output logic          mem_req,
    output logic          busy,
    output logic          done,
    output logic          C,
    output logic          N,
    output logic          Z,
    output logic [DW-1:0] Address,
    output logic [DW-1:0] D_out,
    output logic [DW-1:0] IR,
    output logic [DW-1:0] PC_out
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};

    state_t        state, state_nx;
    logic [DW-1:0] rf [DEPTH];
    logic [DW-1:0] r_op, s_op;
    logic [DW:0]   alu_ext;
    logic [DW-1:0] pc_q, pc_nx, sext;
    logic [DW-1:0] addr_cap, addr_live;
    logic          dst_cap;
    logic [AW-1:0] wadr_cap;
    logic          mem_wb;

    assign r_op = rf[R_Adr];
    assign s_op = s_sel ? DS : rf[S_Adr];

    // alu_ext[DW] carries carry/borrow or the shifted-out bit; zero otherwise.
    always_comb begin
        alu_ext = '0;
        unique case (ALU_OP)
            4'h0: alu_ext = {1'b0, s_op};
            4'h1: alu_ext = {1'b0, r_op};
            4'h2: alu_ext = {1'b0, r_op} + {1'b0, s_op};
            4'h3: alu_ext = {1'b0, r_op} - {1'b0, s_op};
            4'h4: alu_ext = {1'b0, r_op & s_op};
            4'h5: alu_ext = {1'b0, r_op | s_op};
            4'h6: alu_ext = {1'b0, r_op ^ s_op};
            4'h7: alu_ext = {1'b0, ~s_op};
            4'h8: alu_ext = {1'b0, s_op} + ONE;
            4'h9: alu_ext = {1'b0, s_op} - ONE;
            4'hA: alu_ext = {s_op[DW-1], s_op[DW-2:0], 1'b0};
            4'hB: alu_ext = {s_op[0], 1'b0, s_op[DW-1:1]};
            4'hC: alu_ext = {s_op[0], s_op[DW-1], s_op[DW-1:1]};
            4'hD: alu_ext = {(DW+1){1'b0}} - {1'b0, s_op};
            4'hE: alu_ext = '0;
            4'hF: alu_ext = {1'b0, {DW{1'b1}}};
            default: alu_ext = '0;
        endcase
    end

    assign D_out = alu_ext[DW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            C <= 1'b0;
            N <= 1'b0;
            Z <= 1'b0;
        end else if (flag_ld) begin
            C <= alu_ext[DW];
            N <= alu_ext[DW-1];
            Z <= (alu_ext[DW-1:0] == '0);
        end
    end

    assign sext = DW'($signed(IR[OFS_W-1:0]));

    always_comb begin
        pc_nx = pc_q;
        if (pc_ld)
            pc_nx = pc_sel ? D_out : pc_q + sext;
        else if (pc_inc)
            pc_nx = pc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= '0;
        else
            pc_q <= pc_nx;
    end

    assign PC_out = pc_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (mem_start) state_nx = REQ;
            REQ:     if (mem_rdy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    assign mem_req = (state == REQ);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    assign addr_live = adr_sel ? r_op : pc_q;
    assign Address   = busy ? addr_cap : addr_live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cap <= '0;
            dst_cap  <= 1'b0;
            wadr_cap <= '0;
        end else if (state == IDLE && mem_start) begin
            addr_cap <= addr_live;
            dst_cap  <= mem_dst;
            wadr_cap <= W_Adr;
        end
    end

    // A memory writeback owns the single RF write port; a concurrent W_en is dropped.
    assign mem_wb = (state == REQ) && mem_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IR <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                rf[i] <= '0;
        end else begin
            if (mem_wb && dst_cap)
                IR <= DS;
            if (mem_wb && !dst_cap)
                rf[wadr_cap] <= DS;
            else if (W_en)
                rf[W_Adr] <= D_out;
        end
    end

endmodule

// File: tb/tb_exec_unit_param.sv
// Scoreboard bench for exec_unit_param: default 16-bit instance plus an 8-bit/4-entry one.
module tb_exec_unit_param;

    localparam int SEL_DOUT = 0, SEL_C = 1, SEL_N = 2, SEL_Z = 3, SEL_PC = 4, SEL_IR = 5,
                   SEL_ADDR = 6, SEL_REQ = 7, SEL_BUSY = 8, SEL_DONE = 9,
                   SEL_D8 = 10, SEL_C8 = 11, SEL_Z8 = 12, SEL_PC8 = 13, SEL_IR8 = 14;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        W_en, s_sel, flag_ld, pc_ld, pc_sel, pc_inc, adr_sel, mem_start, mem_dst, mem_rdy;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  ALU_OP;
    logic [15:0] DS;
    logic        mem_req, busy, done, C, N, Z;
    logic [15:0] Address, D_out, IR, PC_out;

    logic        W_en8, s_sel8, flag_ld8, pc_ld8, pc_sel8, pc_inc8, adr_sel8, mem_start8, mem_dst8, mem_rdy8;
    logic [1:0]  W_Adr8, R_Adr8, S_Adr8;
    logic [3:0]  ALU_OP8;
    logic [7:0]  DS8;
    logic        mem_req8, busy8, done8, C8, N8, Z8;
    logic [7:0]  Address8, D_out8, IR8, PC_out8;

    exec_unit_param #(.DW(16), .DEPTH(8), .OFS_W(8)) u_dut (
        .clk(clk), .reset(reset), .W_en(W_en), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .s_sel(s_sel), .ALU_OP(ALU_OP), .flag_ld(flag_ld), .pc_ld(pc_ld), .pc_sel(pc_sel),
        .pc_inc(pc_inc), .adr_sel(adr_sel), .mem_start(mem_start), .mem_dst(mem_dst),
        .mem_rdy(mem_rdy), .DS(DS), .mem_req(mem_req), .busy(busy), .done(done),
        .C(C), .N(N), .Z(Z), .Address(Address), .D_out(D_out), .IR(IR), .PC_out(PC_out)
    );

    exec_unit_param #(.DW(8), .DEPTH(4), .OFS_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .W_en(W_en8), .W_Adr(W_Adr8), .R_Adr(R_Adr8), .S_Adr(S_Adr8),
        .s_sel(s_sel8), .ALU_OP(ALU_OP8), .flag_ld(flag_ld8), .pc_ld(pc_ld8), .pc_sel(pc_sel8),
        .pc_inc(pc_inc8), .adr_sel(adr_sel8), .mem_start(mem_start8), .mem_dst(mem_dst8),
        .mem_rdy(mem_rdy8), .DS(DS8), .mem_req(mem_req8), .busy(busy8), .done(done8),
        .C(C8), .N(N8), .Z(Z8), .Address(Address8), .D_out(D_out8), .IR(IR8), .PC_out(PC_out8)
    );

    exp_t        exp_q[$];
    int unsigned done_q[$];
    int unsigned done8_q[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(int unsigned sel);
        case (sel)
            SEL_DOUT: return {16'h0, D_out};
            SEL_C:    return {31'h0, C};
            SEL_N:    return {31'h0, N};
            SEL_Z:    return {31'h0, Z};
            SEL_PC:   return {16'h0, PC_out};
            SEL_IR:   return {16'h0, IR};
            SEL_ADDR: return {16'h0, Address};
            SEL_REQ:  return {31'h0, mem_req};
            SEL_BUSY: return {31'h0, busy};
            SEL_DONE: return {31'h0, done};
            SEL_D8:   return {24'h0, D_out8};
            SEL_C8:   return {31'h0, C8};
            SEL_Z8:   return {31'h0, Z8};
            SEL_PC8:  return {24'h0, PC_out8};
            SEL_IR8:  return {24'h0, IR8};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drains expectations at every falling edge and checks done pulses against their expected cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = exp_q.pop_front();
            got = obs(e.sel);
            vectors++;
            if (got !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        if (done) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done16: unexpected pulse at cycle %0d", cyc);
            end else begin
                int unsigned ec;
                ec = done_q.pop_front();
                if (ec != cyc) begin
                    miscompares++;
                    $display("FAIL done16: pulse at cycle %0d expected %0d", cyc, ec);
                end
            end
        end
        if (done8) begin
            vectors++;
            if (done8_q.size() == 0) begin
                miscompares++;
                $display("FAIL done8: unexpected pulse at cycle %0d", cyc);
            end else begin
                int unsigned ec;
                ec = done8_q.pop_front();
                if (ec != cyc) begin
                    miscompares++;
                    $display("FAIL done8: pulse at cycle %0d expected %0d", cyc, ec);
                end
            end
        end
    end

    task automatic chk(input string name, input int unsigned sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {W_en, s_sel, flag_ld, pc_ld, pc_sel, pc_inc, adr_sel, mem_start, mem_dst, mem_rdy} = '0;
        W_Adr = '0; R_Adr = '0; S_Adr = '0; ALU_OP = '0; DS = '0;
        {W_en8, s_sel8, flag_ld8, pc_ld8, pc_sel8, pc_inc8, adr_sel8, mem_start8, mem_dst8, mem_rdy8} = '0;
        W_Adr8 = '0; R_Adr8 = '0; S_Adr8 = '0; ALU_OP8 = '0; DS8 = '0;
        reset = 1'b1;
        step(); step();
        chk("rst_pc", SEL_PC, 0);      chk("rst_ir", SEL_IR, 0);
        chk("rst_c", SEL_C, 0);        chk("rst_n", SEL_N, 0);       chk("rst_z", SEL_Z, 0);
        chk("rst_req", SEL_REQ, 0);    chk("rst_busy", SEL_BUSY, 0); chk("rst_addr", SEL_ADDR, 0);
        chk("rst_dout", SEL_DOUT, 0);  chk("rst_pc8", SEL_PC8, 0);
        step();
        reset = 1'b0;
        step();

        // RF1 = FFFF, RF2 = 0001
        ALU_OP = 4'hF; W_en = 1; W_Adr = 1; step();
        ALU_OP = 4'h0; s_sel = 1; DS = 16'h0001; W_Adr = 2; step();
        W_en = 0; s_sel = 0;

        // ADD FFFF+1 and SUB 0-1 with flag_ld, then flags hold
        R_Adr = 1; S_Adr = 2; ALU_OP = 4'h2; flag_ld = 1;
        chk("add_dout", SEL_DOUT, 32'h0000);
        step();
        chk("add_c", SEL_C, 1); chk("add_z", SEL_Z, 1); chk("add_n", SEL_N, 0);
        R_Adr = 0; ALU_OP = 4'h3;
        chk("sub_dout", SEL_DOUT, 32'hFFFF);
        step();
        flag_ld = 0; ALU_OP = 4'hE;
        chk("sub_c", SEL_C, 1); chk("sub_n", SEL_N, 1); chk("sub_z", SEL_Z, 0);
        step();
        chk("hold_c", SEL_C, 1); chk("hold_z", SEL_Z, 0);

        // PC = 0010, IR = 00FE by zero-wait fetch
        ALU_OP = 4'h0; s_sel = 1; DS = 16'h0010; pc_ld = 1; pc_sel = 1; step();
        pc_ld = 0; chk("pc_load", SEL_PC, 32'h0010);
        mem_start = 1; mem_dst = 1; adr_sel = 0;
        chk("fetch0_addr", SEL_ADDR, 32'h0010);
        step();
        mem_start = 0; mem_rdy = 1; DS = 16'h00FE;
        chk("fetch0_req", SEL_REQ, 1); chk("fetch0_busy", SEL_BUSY, 1);
        done_q.push_back(cyc + 1);
        step();
        mem_rdy = 0;
        chk("fetch0_ir", SEL_IR, 32'h00FE); chk("fetch0_req_low", SEL_REQ, 0);
        step();
        chk("fetch0_idle", SEL_BUSY, 0);

        // Branch 0010 + sext(FE) = 000E
        pc_ld = 1; pc_sel = 0; step();
        pc_ld = 0; chk("pc_branch", SEL_PC, 32'h000E);
        // FFFF + 1 wraps to 0
        pc_ld = 1; pc_sel = 1; ALU_OP = 4'hF; step();
        pc_ld = 0; chk("pc_ffff", SEL_PC, 32'hFFFF);
        pc_inc = 1; step();
        pc_inc = 0; chk("pc_wrap", SEL_PC, 32'h0000);
        // load beats inc
        pc_ld = 1; pc_inc = 1; pc_sel = 1; ALU_OP = 4'h0; s_sel = 1; DS = 16'h1234; step();
        pc_ld = 0; pc_inc = 0; chk("pc_prio", SEL_PC, 32'h1234);
        DS = 16'h0020; pc_ld = 1; step();
        pc_ld = 0; chk("pc_0020", SEL_PC, 32'h0020);

        // IR fetch with 3 wait states; Address frozen although adr_sel switches to RF1
        adr_sel = 0; mem_start = 1; mem_dst = 1;
        chk("fetch3_addr0", SEL_ADDR, 32'h0020);
        step();
        mem_start = 0; adr_sel = 1; R_Adr = 1; s_sel = 0;
        for (int k = 0; k < 3; k++) begin
            chk("fetch3_addr_wait", SEL_ADDR, 32'h0020);
            chk("fetch3_req_wait", SEL_REQ, 1);
            step();
        end
        mem_rdy = 1; DS = 16'hABCD;
        chk("fetch3_addr_rdy", SEL_ADDR, 32'h0020);
        done_q.push_back(cyc + 1);
        step();
        mem_rdy = 0;
        chk("fetch3_ir", SEL_IR, 32'hABCD); chk("fetch3_req_done", SEL_REQ, 0);
        chk("fetch3_addr_done", SEL_ADDR, 32'h0020);
        step();
        chk("fetch3_idle", SEL_BUSY, 0); chk("addr_live_rf", SEL_ADDR, 32'hFFFF);

        // mem_rdy in IDLE is ignored
        mem_rdy = 1; DS = 16'h5555; step();
        mem_rdy = 0;
        chk("rdy_idle_ir", SEL_IR, 32'hABCD); chk("rdy_idle_busy", SEL_BUSY, 0);
        step();

        // Write-port conflict: captured W_Adr=3 wins, W_en to RF5 dropped; mem_start in REQ/DONE ignored
        adr_sel = 0; mem_start = 1; mem_dst = 0; W_Adr = 3; step();
        W_Adr = 5; chk("conf_busy", SEL_BUSY, 1);
        step();
        mem_rdy = 1; DS = 16'h5A5A; W_en = 1; ALU_OP = 4'hF;
        done_q.push_back(cyc + 1);
        step();
        mem_rdy = 0; W_en = 0;
        step();
        mem_start = 0;
        chk("conf_idle", SEL_BUSY, 0);
        ALU_OP = 4'h1; R_Adr = 3;
        chk("conf_rf3", SEL_DOUT, 32'h5A5A);
        step();
        R_Adr = 5;
        chk("conf_rf5", SEL_DOUT, 32'h0000);
        step();

        // 8-bit instance: IR=0F, branch from 00 gives FF; SHL 0x80
        mem_start8 = 1; mem_dst8 = 1; step();
        mem_start8 = 0; mem_rdy8 = 1; DS8 = 8'h0F;
        done8_q.push_back(cyc + 1);
        step();
        mem_rdy8 = 0;
        chk("w8_ir", SEL_IR8, 32'h0F);
        step();
        pc_ld8 = 1; pc_sel8 = 0; step();
        pc_ld8 = 0; chk("w8_branch", SEL_PC8, 32'hFF);
        pc_inc8 = 1; step();
        pc_inc8 = 0; chk("w8_wrap", SEL_PC8, 32'h00);
        s_sel8 = 1; DS8 = 8'h80; ALU_OP8 = 4'hA; flag_ld8 = 1;
        chk("w8_shl_dout", SEL_D8, 32'h00);
        step();
        flag_ld8 = 0;
        chk("w8_shl_c", SEL_C8, 1); chk("w8_shl_z", SEL_Z8, 1);
        step();

        // Reset pulse mid-REQ, released before the next rising edge
        adr_sel = 0; mem_start = 1; mem_dst = 1; step();
        mem_start = 0;
        chk("mid_req_on", SEL_REQ, 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        mem_rdy = 1; DS = 16'h7777; R_Adr = 3; ALU_OP = 4'h1;
        chk("abort_req", SEL_REQ, 0);  chk("abort_busy", SEL_BUSY, 0);
        chk("abort_pc", SEL_PC, 0);    chk("abort_ir", SEL_IR, 0);
        chk("abort_rf3", SEL_DOUT, 0);
        step();
        mem_rdy = 0;
        step();
        chk("abort_ir_late", SEL_IR, 0); chk("abort_busy_late", SEL_BUSY, 0);
        step(); step();

        if (done_q.size() != 0 || done8_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_missing: got %0d/%0d pending pulses expected 0/0", done_q.size(), done8_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
